// File: rtl/iomem_fabric.sv
// iomem_fabric: registered, handshaked register-bus fabric between the SPI
// register bridge (master) and NUM_T peripheral register targets.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   m_valid/m_wen/      master request (held until m_ready), direction,
//   m_addr/m_wdata      byte address and write data
//   m_ready/m_rdata     one-cycle completion pulse, read data (held)
//   t_valid             one-hot target request, held until t_ready
//   t_wen/t_addr/       shared write enable, in-region address and
//   t_wdata             write data to the targets
//   t_ready/t_rdata     per-target completion pulse and read data slices
//   err_sticky/         timeout flag, address of the first timed-out access,
//   err_addr/err_count  saturating timeout count
//   err_clr             synchronous clear of the error state
module iomem_fabric #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned REGION_BITS = 2,
  parameter int unsigned DATA_W      = 32,
  parameter logic [(2**REGION_BITS)-1:0] TARGET_MASK = 4'b0101,
  parameter logic [DATA_W-1:0] UNMAPPED_RDATA = 32'hffffffff,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = 32'hdeadbeef,
  localparam int unsigned NUM_T      = 2**REGION_BITS,
  localparam int unsigned TA_W       = ADDR_W - REGION_BITS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    m_valid,
  input  logic                    m_wen,
  input  logic [ADDR_W-1:0]       m_addr,
  input  logic [DATA_W-1:0]       m_wdata,
  output logic                    m_ready,
  output logic [DATA_W-1:0]       m_rdata,
  output logic [NUM_T-1:0]        t_valid,
  output logic                    t_wen,
  output logic [TA_W-1:0]         t_addr,
  output logic [DATA_W-1:0]       t_wdata,
  input  logic [NUM_T-1:0]        t_ready,
  input  logic [NUM_T*DATA_W-1:0] t_rdata,
  output logic                    err_sticky,
  output logic [ADDR_W-1:0]       err_addr,
  output logic [7:0]              err_count,
  input  logic                    err_clr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                 state, state_nx;
  logic [REGION_BITS-1:0] region_q;
  logic [16:0]            cnt;
  logic [DATA_W-1:0]      rd_q;
  logic                   upd_q;

  logic [REGION_BITS-1:0] m_region;
  logic                   mapped;
  logic                   accept;
  logic                   sel_ready;
  logic [DATA_W-1:0]      sel_rdata;
  logic                   hit_limit;
  logic                   timeout;

  assign m_region  = m_addr[ADDR_W-1 -: REGION_BITS];
  assign mapped    = TARGET_MASK[m_region];
  // m_ready is registered out of DONE, so the IDLE cycle carrying the pulse
  // must not accept a request that the master is still holding.
  assign accept    = (state == IDLE) && m_valid && !m_ready;
  assign sel_ready = t_ready[region_q];
  assign sel_rdata = t_rdata[region_q*DATA_W +: DATA_W];
  assign hit_limit = (cnt + 17'd1) == 17'(TIMEOUT);
  assign timeout   = (state == ACCESS) && !sel_ready && hit_limit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = mapped ? ACCESS : DONE;
      ACCESS:  if (sel_ready || hit_limit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Completion data is staged in rd_q and only published with m_ready, so
  // m_rdata stays stable until the next completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready  <= 1'b0;
      m_rdata  <= '0;
      t_valid  <= '0;
      t_wen    <= 1'b0;
      t_addr   <= '0;
      t_wdata  <= '0;
      region_q <= '0;
      cnt      <= '0;
      rd_q     <= '0;
      upd_q    <= 1'b0;
    end else begin
      m_ready <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            t_wen    <= m_wen;
            t_addr   <= m_addr[TA_W-1:0];
            t_wdata  <= m_wdata;
            region_q <= m_region;
            cnt      <= '0;
            upd_q    <= !m_wen;
            if (mapped) t_valid <= NUM_T'(1) << m_region;
            else        rd_q    <= UNMAPPED_RDATA;
          end
        end
        ACCESS: begin
          cnt <= cnt + 17'd1;
          if (sel_ready) begin
            t_valid <= '0;
            rd_q    <= sel_rdata;
            upd_q   <= !t_wen;
          end else if (hit_limit) begin
            t_valid <= '0;
            rd_q    <= TIMEOUT_RDATA;
            upd_q   <= !t_wen;
          end
        end
        DONE: begin
          if (upd_q) m_rdata <= rd_q;
          upd_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A timeout in the same cycle as err_clr restarts the error record.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
      err_count  <= '0;
    end else if (timeout) begin
      err_sticky <= 1'b1;
      if (!err_sticky || err_clr) err_addr <= {region_q, t_addr};
      if (err_clr)                err_count <= 8'd1;
      else if (err_count != 8'hff) err_count <= err_count + 8'd1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
      err_count  <= '0;
    end
  end

endmodule

// File: tb/tb_iomem_fabric.sv
module tb_iomem_fabric;

  localparam int unsigned T = 8;
  localparam logic [3:0]  MASK = 4'b0101;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         m_valid, m_wen;
  logic [13:0]  m_addr;
  logic [31:0]  m_wdata;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   t_valid;
  logic         t_wen;
  logic [11:0]  t_addr;
  logic [31:0]  t_wdata;
  logic [3:0]   t_ready;
  logic [127:0] t_rdata;
  logic         err_sticky;
  logic [13:0]  err_addr;
  logic [7:0]   err_count;
  logic         err_clr;

  iomem_fabric #(
    .ADDR_W(14), .REGION_BITS(2), .DATA_W(32), .TARGET_MASK(MASK),
    .UNMAPPED_RDATA(32'hffffffff), .TIMEOUT(T), .TIMEOUT_RDATA(32'hdeadbeef)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_valid(m_valid), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .t_valid(t_valid), .t_wen(t_wen), .t_addr(t_addr), .t_wdata(t_wdata),
    .t_ready(t_ready), .t_rdata(t_rdata),
    .err_sticky(err_sticky), .err_addr(err_addr), .err_count(err_count),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference state: last published read data and the error record.
  logic [31:0] exp_rdata;
  logic        e_sticky;
  logic [13:0] e_addr;
  int unsigned e_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_errs(input string tag);
    check_eq({tag, " err_sticky"}, 64'(err_sticky), 64'(e_sticky));
    check_eq({tag, " err_addr"},   64'(err_addr),   64'(e_addr));
    check_eq({tag, " err_count"},  64'(err_count),  64'(e_cnt));
  endtask

  // One master transaction, starting and ending on a negedge. ready_at is the
  // ACCESS cycle (1-based) in which the target answers; 0 means never.
  task automatic run_txn(input logic [13:0] addr, input logic wen, input logic [31:0] wdata,
                         input int unsigned ready_at, input logic [31:0] rval, input logic clr_on_to);
    logic [1:0]  r;
    logic        mapped, ok;
    int unsigned acc, lat;
    logic [31:0] old_rdata;
    logic [3:0]  tv_exp;
    r         = addr[13:12];
    mapped    = MASK[r];
    ok        = mapped && ready_at >= 1 && ready_at <= T;
    acc       = !mapped ? 0 : (ok ? ready_at : T);
    lat       = 2 + acc;
    old_rdata = exp_rdata;
    tv_exp    = 4'b0001 << r;

    if (!wen) begin
      if (!mapped)  exp_rdata = 32'hffffffff;
      else if (ok)  exp_rdata = rval;
      else          exp_rdata = 32'hdeadbeef;
    end
    if (mapped && !ok) begin
      if (clr_on_to) begin
        e_cnt  = 1;
        e_addr = addr;
      end else begin
        if (!e_sticky) e_addr = addr;
        if (e_cnt < 255) e_cnt++;
      end
      e_sticky = 1'b1;
    end

    m_valid = 1'b1; m_wen = wen; m_addr = addr; m_wdata = wdata;
    for (int unsigned c = 1; c <= lat; c++) begin
      @(negedge clk);
      check_eq("m_ready", 64'(m_ready), 64'(c == lat));
      check_eq("t_valid", 64'(t_valid), (mapped && c <= acc) ? 64'(tv_exp) : 64'd0);
      if (c == 1 && mapped) begin
        check_eq("t_addr",  64'(t_addr),  64'(addr[11:0]));
        check_eq("t_wen",   64'(t_wen),   64'(wen));
        check_eq("t_wdata", 64'(t_wdata), 64'(wdata));
      end
      if (c < lat) check_eq("m_rdata held", 64'(m_rdata), 64'(old_rdata));
      else begin
        check_eq("m_rdata", 64'(m_rdata), 64'(exp_rdata));
        check_errs("txn");
      end
      // Target side for the cycle now in progress; other targets chatter.
      t_ready = 4'($urandom);
      t_ready[r] = ok && (c == ready_at);
      t_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (ok && c == ready_at) t_rdata[r*32 +: 32] = rval;
      err_clr = clr_on_to && mapped && !ok && (c == T);
      if (c == lat) m_valid = 1'b0;
    end
    t_ready = '0;
    err_clr = 1'b0;
    @(negedge clk);
    check_eq("m_ready single pulse", 64'(m_ready), 64'd0);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    e_sticky = 1'b0; e_addr = '0; e_cnt = 0;
    check_errs("clear");
  endtask

  initial begin
    reset_n = 1'b0; m_valid = 1'b0; m_wen = 1'b0; m_addr = '0; m_wdata = '0;
    t_ready = '0; t_rdata = '0; err_clr = 1'b0;
    exp_rdata = '0; e_sticky = 1'b0; e_addr = '0; e_cnt = 0;
    repeat (2) @(negedge clk);
    check_eq("reset m_ready", 64'(m_ready), 64'd0);
    check_eq("reset m_rdata", 64'(m_rdata), 64'd0);
    check_eq("reset t_valid", 64'(t_valid), 64'd0);
    check_eq("reset t_wen",   64'(t_wen),   64'd0);
    check_eq("reset t_addr",  64'(t_addr),  64'd0);
    check_eq("reset t_wdata", 64'(t_wdata), 64'd0);
    check_errs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_txn(14'h0010, 1'b0, 32'h0, 2, 32'h00001234, 1'b0);
    run_txn(14'h1000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    run_txn(14'h2024, 1'b1, 32'hcafef00d, 1, 32'h55555555, 1'b0);
    run_txn(14'h3004, 1'b1, 32'h12345678, 0, 32'h0, 1'b0);
    run_txn(14'h0abc, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    run_txn(14'h0123, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    clear_errs();

    // Boundary: answer on the limit cycle succeeds, one later times out
    run_txn(14'h2100, 1'b0, 32'h0, T, 32'ha5a5a5a5, 1'b0);
    run_txn(14'h2200, 1'b0, 32'h0, T + 1, 32'h5a5a5a5a, 1'b0);
    run_txn(14'h0040, 1'b0, 32'h0, 1, 32'h0badf00d, 1'b0);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 120; i++) begin
      run_txn(14'($urandom), 1'($urandom), $urandom, $urandom_range(0, 10), $urandom, 1'b0);
      if ($urandom_range(0, 15) == 0) clear_errs();
    end

    // Saturation, then clear colliding with a timeout
    clear_errs();
    for (int i = 0; i < 300; i++) run_txn(14'h0200, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    check_eq("err_count saturated", 64'(err_count), 64'd255);
    run_txn(14'h2300, 1'b0, 32'h0, 0, 32'h0, 1'b1);
    check_eq("clr+timeout count", 64'(err_count), 64'd1);
    check_eq("clr+timeout sticky", 64'(err_sticky), 64'd1);
    check_eq("clr+timeout addr", 64'(err_addr), 64'h2300);

    // Asynchronous reset in the middle of ACCESS
    m_valid = 1'b1; m_wen = 1'b0; m_addr = 14'h0080;
    repeat (3) @(negedge clk);
    check_eq("pre-reset t_valid", 64'(t_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    m_valid = 1'b0;
    check_eq("async t_valid", 64'(t_valid), 64'd0);
    check_eq("async m_ready", 64'(m_ready), 64'd0);
    check_eq("async m_rdata", 64'(m_rdata), 64'd0);
    exp_rdata = '0; e_sticky = 1'b0; e_addr = '0; e_cnt = 0;
    check_errs("async");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post-reset m_ready", 64'(m_ready), 64'd0);
      check_eq("post-reset t_valid", 64'(t_valid), 64'd0);
    end
    run_txn(14'h0090, 1'b0, 32'h0, 3, 32'h0000beef, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iomem_fabric.md
Name: iomem_fabric

Overview:
Parametrised register-bus fabric between the SPI register bridge (master side) and N peripheral register targets: VIDC capture, video output, CG memory and future blocks. Replaces fixed combinational region decode and read-mux with a registered, handshaked transaction engine. Adds per-target ready/wait states, unmapped-region default responses, timeouts with sticky error capture, and a saturating error counter readable by the MCU.

Parameters:
ADDR_W, 14, master byte-address width
REGION_BITS, 2, top address bits selecting target; NUM_T = 2**REGION_BITS
DATA_W, 32, data width
TARGET_MASK, 4'b0101, bit i=1 means region i is populated
UNMAPPED_RDATA, 32'hffffffff, read data returned for unpopulated regions
TIMEOUT, 255, max cycles waiting for t_ready (1..65535)
TIMEOUT_RDATA, 32'hdeadbeef, read data returned on timeout

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m_valid  in  1  master request; held high until m_ready
m_wen  in  1  1=write, 0=read; stable while m_valid
m_addr  in  ADDR_W  byte address
m_wdata  in  DATA_W  write data
m_ready  out  1  one-cycle completion pulse
m_rdata  out  DATA_W  read data; valid when m_ready=1, held until next completion
t_valid  out  NUM_T  one-hot target request; held until that target's t_ready
t_wen  out  1  shared write enable
t_addr  out  ADDR_W-REGION_BITS  shared in-region address
t_wdata  out  DATA_W  shared write data
t_ready  in  NUM_T  per-target completion pulse
t_rdata  in  NUM_T*DATA_W  per-target read data; slice i valid with t_ready[i]
err_sticky  out  1  set on any timeout; cleared by err_clr
err_addr  out  ADDR_W  address of first timed-out access since last clear
err_count  out  8  timeouts, saturates at 255
err_clr  in  1  synchronous clear of err_sticky/err_addr/err_count

Behaviour:
- Reset (async, reset_n=0): state IDLE; m_ready=0, m_rdata=0, t_valid=0, t_wen=0, t_addr=0, t_wdata=0, err_sticky=0, err_addr=0, err_count=0, timeout counter=0.
- States IDLE, ACCESS, DONE.
- IDLE: on m_valid=1, latch m_wen, m_addr, m_wdata. Compute region r = m_addr[ADDR_W-1 -: REGION_BITS].
  - If TARGET_MASK[r]=1: go to ACCESS next cycle with t_valid[r]=1. t_addr = m_addr low bits, t_wen and t_wdata from the latch. Timeout counter = 0.
  - Else: go to DONE with m_rdata=UNMAPPED_RDATA (reads). Writes are discarded.
- ACCESS: counter increments each cycle.
  - If t_ready[r]=1: capture t_rdata slice r into m_rdata on a read; leave m_rdata unchanged on a write. Drop t_valid and go to DONE.
  - If counter reaches TIMEOUT without t_ready: drop t_valid. Read data = TIMEOUT_RDATA. err_count += 1, saturating at 255. If err_sticky=0, load err_addr; then set err_sticky. Go to DONE.
  - t_ready[r] on the same cycle the counter reaches TIMEOUT counts as success, not timeout.
  - t_ready on non-selected targets, or in IDLE/DONE, is ignored.
- DONE: m_ready=1 for exactly one cycle, then go to IDLE.
  - A new m_valid is not accepted until the cycle after m_ready. If m_valid is still high then, it is a new transaction.
- Latency:
  - Unmapped: m_ready 2 cycles after m_valid is sampled.
  - Mapped: 3 cycles if t_ready is asserted on the first ACCESS cycle; in general 2 + ACCESS cycles.
- err_clr: clears all error state. If err_clr and a timeout occur in the same cycle, the timeout wins: err_sticky=1, err_count=1, err_addr set.
- m_valid dropping mid-transaction is illegal. The fabric completes the transaction regardless.
- Reset mid-ACCESS aborts immediately: t_valid=0, and no m_ready is produced.

Test Plan:
- Mapped read: region 0, t_ready[0] asserted on the 2nd ACCESS cycle with t_rdata slice 0 = 32'h00001234 -> m_ready high 4 cycles after m_valid sampled, m_rdata=32'h00001234, t_valid=4'b0001 only during ACCESS.
- Unmapped read: m_addr=14'h1000 (region 1, mask 0101) -> no t_valid asserted, m_ready after 2 cycles, m_rdata=32'hffffffff.
- Write to region 2, m_wdata=32'hcafef00d, addr 14'h2024 -> t_valid=4'b0100, t_addr=12'h024, t_wdata=32'hcafef00d, t_wen=1; m_rdata unchanged after completion.
- Timeout with TIMEOUT=8 and region 0 never ready -> t_valid drops after 8 cycles, m_rdata=32'hdeadbeef, err_sticky=1, err_count=1, err_addr=m_addr. A second timeout at a different address leaves err_addr unchanged and gives err_count=2.
- Saturation and clear: 300 timeouts -> err_count=255. Asserting err_clr together with a timeout -> err_count=1, err_sticky=1.
- Async reset mid-ACCESS -> all outputs 0 immediately with no m_ready pulse. After release, the next read completes normally.
